// File: rtl/ALU_def.sv
// ALU_def -- shared definitions for the datapath ALU and its clients.
//   ALU_CTRL  : operation select driven to the shared ALU.
//   MUL_STATE : state encoding of the sequential multiplier mul_seq.
//   MUL_W     : operand width handled by mul_seq.
//   LAST_SHIFT: shift-counter value of the final (eighth) shift.
package ALU_def;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } ALU_CTRL;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } MUL_STATE;

    localparam int unsigned MUL_W      = 8;
    localparam logic [3:0]  LAST_SHIFT = 4'd7;

endpackage

// File: rtl/mul_seq.sv
// mul_seq -- 8x8 unsigned shift-and-add multiplier that borrows the shared
// datapath ALU for its additions (one ADD per set multiplier bit, one SHIFT
// per multiplier bit).
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, op_a, op_b  : multiply request; operands captured on acceptance
//   busy               : high in ADD and SHIFT
//   done               : one-cycle pulse when prod is valid
//   prod               : registered product, held until the next accepted start
//   alu_req / alu_gnt  : request / grant to the shared-ALU arbiter
//   alu_ctrl, alu_a, alu_b, alu_cin : operation and operands to the ALU
//   alu_out, alu_cout  : ALU result
module mul_seq
    import ALU_def::*;
#(
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MUL_W-1:0]  op_a,
    input  logic [MUL_W-1:0]  op_b,
    output logic              busy,
    output logic              done,
    output logic [2*MUL_W-1:0] prod,
    output logic              alu_req,
    input  logic              alu_gnt,
    output ALU_CTRL           alu_ctrl,
    output logic [MUL_W-1:0]  alu_a,
    output logic [MUL_W-1:0]  alu_b,
    output logic              alu_cin,
    input  logic [MUL_W-1:0]  alu_out,
    input  logic              alu_cout
);

    MUL_STATE                 state_q, state_d;
    logic [MUL_W-1:0]         hi_q, hi_d;
    logic [MUL_W-1:0]         lo_q, lo_d;
    logic [MUL_W-1:0]         mcand_q, mcand_d;
    logic                     carry_q, carry_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [2*MUL_W-1:0]       prod_q, prod_d;

    // {carry,hi,lo} shifted right by one, zero filled from the top.
    logic [2*MUL_W:0]         shifted;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        shifted = {1'b0, carry_q, hi_q, lo_q[MUL_W-1:1]};

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                // start is only honoured here; in ADD/SHIFT it is ignored.
                if (start) begin
                    hi_d    = '0;
                    lo_d    = op_b;
                    mcand_d = op_a;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    if (ZERO_SKIP && ((op_a == '0) || (op_b == '0))) begin
                        prod_d  = '0;
                        state_d = DONE;
                    end else if (op_b[0]) begin
                        state_d = ADD;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            ADD: begin
                // Without a grant the ALU result is not ours: hold and retry.
                // ADD is only entered with lo[0]=1; the guard keeps the
                // accumulate tied to the multiplier bit it represents.
                if (alu_gnt) begin
                    if (lo_q[0]) begin
                        hi_d    = alu_out;
                        carry_d = alu_cout;
                    end
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {carry_d, hi_d, lo_d} = shifted;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_SHIFT) begin
                    prod_d  = shifted[2*MUL_W-1:0];
                    state_d = DONE;
                end else if (shifted[0]) begin
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        busy     = (state_q == ADD) || (state_q == SHIFT);
        done     = (state_q == DONE);
        alu_req  = (state_q == ADD);
        alu_ctrl = ALU_ADD;
        alu_cin  = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        if (state_q == ADD) begin
            alu_a = hi_q;
            alu_b = mcand_q;
        end
    end

    assign prod = prod_q;

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter ZERO_SKIP, default 0: when 1, an operand of zero at start skips the iteration and finishes with product 0.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request an 8x8 unsigned multiply.
REQ-005 SHALL have port op_a  input  8  multiplicand, sampled when start is accepted.
REQ-006 SHALL have port op_b  input  8  multiplier, sampled when start is accepted.
REQ-007 SHALL have port busy  output  1  high in ADD and SHIFT states.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the product is valid.
REQ-009 SHALL have port prod  output  16  registered product; held until the next accepted start.
REQ-010 SHALL have port alu_req  output  1  requests the shared ALU; high only in ADD state.
REQ-011 SHALL have port alu_gnt  input  1  arbiter grant; the ALU result is used only in cycles where alu_gnt=1.
REQ-012 SHALL have ports alu_ctrl (output, ALU_CTRL), alu_a (output, 8), alu_b (output, 8) and alu_cin (output, 1): drive values to the shared ALU.
REQ-013 SHALL have ports alu_out (input, 8) and alu_cout (input, 1): results from the shared ALU.

Function
REQ-014 SHALL implement states IDLE, ADD, SHIFT, DONE.
- Internal registers: hi[7:0], lo[7:0], mcand[7:0], carry, cnt[3:0].
REQ-015 SHALL accept start only in IDLE or DONE. On acceptance:
- hi=0, lo=op_b, mcand=op_a, carry=0, cnt=0, prod unchanged.
- Next state: ADD if op_b[0]=1, else SHIFT.
REQ-016 SHALL ignore start while busy=1: no restart and no operand capture.
REQ-017 SHALL, in ADD state, drive alu_ctrl=ALU_ADD, alu_a=hi, alu_b=mcand, alu_cin=0, alu_req=1.
REQ-018 SHALL, in ADD state with alu_gnt=1, load hi=alu_out and carry=alu_cout, then go to SHIFT.
REQ-019 SHALL, in ADD state with alu_gnt=0, hold all registers and stay in ADD (stall, unbounded).
REQ-020 SHALL, outside ADD state, drive alu_ctrl=ALU_ADD, alu_a=0, alu_b=0, alu_cin=0, alu_req=0.
REQ-021 SHALL, in SHIFT state:
- Shift right by one: {carry,hi,lo} <= {1'b0,carry,hi,lo[7:1]} in 17-bit arithmetic.
- cnt <= cnt+1.
REQ-022 SHALL, from SHIFT with cnt=7 (eighth shift), load prod={new hi, new lo} and go to DONE.
- Otherwise go to ADD if the new lo[0]=1, else SHIFT.
REQ-023 SHALL assert done=1 in DONE for exactly one cycle, then go to IDLE unless start is accepted in that cycle.
REQ-024 SHALL, with no stalls, take 8+popcount(op_b) busy cycles from start acceptance, followed by one DONE cycle.
REQ-025 SHALL, with ZERO_SKIP=1 and op_a=0 or op_b=0 at acceptance, go directly to DONE with prod=0.
- The ALU is never requested in this case.
REQ-026 SHALL produce the exact unsigned product; overflow is impossible (max 0xFE01).

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=IDLE, hi=lo=mcand=0, carry=0, cnt=0, prod=0, busy=0, done=0, alu_req=0.
REQ-028 SHALL treat reset during ADD, SHIFT or DONE as an abort: no done pulse follows, and the partial product is discarded.
REQ-029 SHALL require a fresh start after reset release; a start level held through reset is accepted at the first edge after release.

Structure
REQ-030 SHALL import ALU_CTRL from package ALU_def.
- The state enum MUL_STATE (IDLE, ADD, SHIFT, DONE) SHALL be added to ALU_def.
REQ-031 SHALL instantiate no ALU; it connects to the shared ALU through the alu_* ports, alongside the datapath's arbiter.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 op_a=13, op_b=11, alu_gnt=1 -> busy for 11 cycles, done pulse, prod=0x008F.
REQ-034 op_a=255, op_b=255, alu_gnt=1 -> busy 16 cycles, prod=0xFE01, alu_req high in 8 non-consecutive cycles.
REQ-035 op_a=200, op_b=3, alu_gnt low for 5 cycles in the first ADD -> busy 15 cycles, prod=0x0258, registers stable during stall.
REQ-036 ZERO_SKIP=0, op_a=0, op_b=0x80 -> busy 9 cycles, prod=0; ZERO_SKIP=1 -> done the cycle after acceptance, prod=0, alu_req never high.
REQ-037 Start op_a=7, op_b=9; pulse start with op_a=1, op_b=1 at cycle 3 -> second start ignored, prod=0x003F.
REQ-038 Start op_a=5, op_b=5; rst_n low at cycle 4 -> outputs 0 immediately, no done pulse; next start op_a=2, op_b=3 -> prod=0x0006.
